fifo_rd_port: RTL
=================

FIFO_RD_PORT -- requirements
Module: fifo_rd_port

Interface
REQ-001 Parameter PTR_WIDTH, default 3: memory address width; pointers are PTR_WIDTH+1 bits.
REQ-002 Parameter DEPTH, default 8: word count; SHALL equal 2**PTR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 8: word width.
REQ-004 rclk  in  1: read-domain clock; the block's only clock.
REQ-005 rrst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 wptr_gray  in  PTR_WIDTH+1: write pointer, Gray-coded, from the write domain (asynchronous to rclk).
REQ-007 rdata_mem  in  DATA_WIDTH: combinational read data from the FIFO memory at raddr.
REQ-008 raddr  out  PTR_WIDTH: memory read address.
REQ-009 rptr_gray  out  PTR_WIDTH+1: registered Gray read pointer, sent to the write domain.
REQ-010 empty  out  1: registered empty flag.
REQ-011 rcount  out  PTR_WIDTH+1: words in memory not yet popped, excluding the output register.
REQ-012 m_valid  out  1: output stream valid.
REQ-013 m_ready  in  1: output stream ready.
REQ-014 m_data  out  DATA_WIDTH: output stream data, registered.

Function
REQ-015 Internal binary read pointer rbin, PTR_WIDTH+1 bits; raddr SHALL equal rbin[PTR_WIDTH-1:0].
REQ-016 wptr_gray SHALL pass through a 2-flop synchronizer (wq2_gray) before any use; no other logic on the asynchronous path.
REQ-017 pop = !empty && (!m_valid || m_ready); on pop, m_data <= rdata_mem, m_valid <= 1, rbin <= rbin+1 (modulo 2**(PTR_WIDTH+1)).
REQ-018 Without pop, m_valid SHALL clear only when m_valid && m_ready; m_data SHALL hold while m_valid && !m_ready.
REQ-019 Simultaneous m_ready and pop SHALL replace the word in the same cycle; sustained throughput is 1 word/rclk.
REQ-020 rptr_gray SHALL register bin2gray(rbin_next), where rbin_next = rbin + pop.
REQ-021 empty SHALL register (bin2gray(rbin_next) == wq2_gray).
REQ-022 rcount SHALL register gray2bin(wq2_gray) - rbin_next, modulo 2**(PTR_WIDTH+1); its range is 0..DEPTH.
REQ-023 Latency: a wptr_gray change sampled at edge N SHALL clear empty at edge N+2, and m_valid SHALL assert at edge N+3.
REQ-024 Pointer wrap (MSB toggle) SHALL be transparent: raddr wraps DEPTH-1 to 0, and ordering is preserved.
REQ-025 The block SHALL never pop while empty=1, regardless of m_ready.

Reset
REQ-026 rrst_n low SHALL immediately force rbin=0, rptr_gray=0, the synchronizer flops to 0, empty=1, rcount=0, m_valid=0, and m_data=0.
REQ-027 Reset mid-transfer SHALL discard the word held in the output register; the write domain is reset concurrently by the system.
REQ-028 Deassertion is treated as synchronous to rclk; the first pop is possible no earlier than 3 edges after deassertion.

Structure
REQ-029 The shared package fifo_pkg SHALL hold the PTR_WIDTH/DEPTH/DATA_WIDTH defaults and the bin2gray and gray2bin functions.
REQ-030 Sub-module sync_2ff (parameterised width, rclk, rrst_n) SHALL implement REQ-016; the write side reuses it.

Verification
REQ-031 Reset: pulse rrst_n low with m_valid=1 and rbin=5 -> m_valid=0, empty=1, raddr=0, and rptr_gray=0000 without a clock edge.
REQ-032 Single word: mem[0]=0xA5, wptr_gray 0000->0001, m_ready=1 -> empty=0 at edge +2, m_valid=1 and m_data=0xA5 at edge +3, and rptr_gray=0001.
REQ-033 Backpressure: 3 words (0x11, 0x22, 0x33), m_ready=0 -> m_data holds 0x11, raddr=1, and rcount=2; releasing m_ready yields 0x22 and 0x33 on consecutive cycles.
REQ-034 Wrap: 9 words through with m_ready=1 -> rptr_gray goes 0100->1100 at the 7->8 step, raddr goes 7->0, and data arrives in order.
REQ-035 Full: wptr_gray=1100 with rbin=0 -> rcount=8; streaming with m_ready=1 produces 8 words on 8 consecutive cycles, then empty=1.
REQ-036 Random: m_ready toggling randomly against a scoreboard -> no loss, no duplication, and no pop while empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and Gray-code helpers used by both pointer domains.
// Helpers work on a 32-bit vector; callers zero-extend and truncate to pointer width.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF  = 3;
  localparam int DEPTH_DEF      = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int GRAY_W         = 32;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero, so truncating the result gives the narrow conversion.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_port.sv
// Read side of an async FIFO: pointer sync, empty/count flags and a one-word
// registered valid/ready output stage that sustains one word per rclk.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH  = PTR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    wptr_gray,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [PTR_WIDTH-1:0]  raddr,
  output logic [PTR_WIDTH:0]    rptr_gray,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    rcount,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef logic [PTR_WIDTH:0] ptr_t;

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("fifo_rd_port: DEPTH must equal 2**PTR_WIDTH");
  end
  if (PTR_WIDTH + 1 > GRAY_W) begin : g_bad_width
    $error("fifo_rd_port: pointer wider than Gray helper width");
  end

  ptr_t wq2_gray;
  ptr_t rbin;
  ptr_t rbin_next;
  ptr_t rgray_next;
  ptr_t wq2_bin;
  ptr_t rcount_next;
  logic pop;

  sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_sync_wptr (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .d      (wptr_gray),
    .q      (wq2_gray)
  );

  // Pop refills the output register whenever it is free or being drained this cycle.
  always_comb begin
    pop         = !empty && (!m_valid || m_ready);
    rbin_next   = rbin + ptr_t'(pop);
    rgray_next  = ptr_t'(bin2gray(GRAY_W'(rbin_next)));
    wq2_bin     = ptr_t'(gray2bin(GRAY_W'(wq2_gray)));
    rcount_next = wq2_bin - rbin_next;
  end

  assign raddr = rbin[PTR_WIDTH-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      empty     <= 1'b1;
      rcount    <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      empty     <= (rgray_next == wq2_gray);
      rcount    <= rcount_next;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (pop) begin
      m_valid <= 1'b1;
      m_data  <= rdata_mem;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
